lutram_sync_fifo: RTL
=====================

Name: lutram_sync_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO controller.
- Acts as the writer and reader for the distributed-RAM storage primitive xilinx_lutram:
  - drives its write port (wren/wraddress/data);
  - consumes its asynchronous read port (rdaddress/q).
- Used as the shallow elastic buffer in the if_cbb datapaths wherever a block RAM is too large.

Parameters:
- DATA_WIDTH, 8: payload width in bits; passed as RAM_WIDTH.
- ADDR_WIDTH, 5: log2 of depth; passed as RAM_DEEP; legal range 5..8; DEPTH = 2**ADDR_WIDTH.
- AFULL_LEVEL, 28: afull asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.
- AEMPTY_LEVEL, 2: aempty asserts when count <= AEMPTY_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock for all logic, and for clk_wr/clk_rd of the storage.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- full  out  1  FIFO holds DEPTH entries.
- afull  out  1  almost full.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_WIDTH  head-of-FIFO data; valid whenever empty==0.
- empty  out  1  FIFO holds 0 entries.
- aempty  out  1  almost empty.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: wr_en while full.
- underflow  out  1  one-cycle pulse: rd_en while empty.

Behaviour:
- Reset is asynchronous active-low. On reset:
  - wr_ptr=0, rd_ptr=0, count=0;
  - empty=1, aempty=1, full=0, afull=0, overflow=0, underflow=0.
  - rd_data is don't-care while empty.
- Pointers are ADDR_WIDTH+1 bits with a wrap MSB.
  - The low ADDR_WIDTH bits drive wraddress/rdaddress.
  - Pointers wrap naturally at 2**(ADDR_WIDTH+1).
- Write acceptance: wr_acc = wr_en & ~full.
  - Storage wren = wr_acc; data = wr_data.
  - wr_ptr increments on wr_acc.
- Read acceptance: rd_acc = rd_en & ~empty.
  - rd_ptr increments on rd_acc.
- FWFT read path:
  - rd_data = storage q at rd_ptr[ADDR_WIDTH-1:0]. The read is combinational, with zero added latency.
  - After rd_acc, the next entry appears on rd_data in the following cycle.
- Storage reset and rden inputs are tied inactive/1; contents are never cleared.
- Write-to-read latency: a word written in cycle N (FIFO empty) gives empty=0 and valid rd_data in cycle N+1.
- count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Flags are registered, computed from next-state count:
  - empty = (count_nxt==0);
  - full = (count_nxt==DEPTH);
  - afull = (count_nxt>=AFULL_LEVEL);
  - aempty = (count_nxt<=AEMPTY_LEVEL).
- Simultaneous events:
  - Full + wr_en + rd_en: write rejected (overflow pulses), read accepted; count becomes DEPTH-1. Full does not look ahead.
  - Empty + wr_en + rd_en: write accepted, read ignored (underflow pulses); count becomes 1.
  - Both accepted mid-range: count unchanged; pointers both advance.
- overflow and underflow are registered: they pulse in the cycle after the offending request.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight write in that cycle is lost.

Optional Feature:
- Macro: LUTRAM_SYNC_FIFO_ERR_STAT_EN.
- Defined: adds three ports:
  - err_clr  in  1;
  - ovf_cnt  out  16;
  - udf_cnt  out  16.
- Counter behaviour when defined:
  - ovf_cnt/udf_cnt are saturating at 16'hFFFF, increment on each overflow/underflow pulse, and reset to 0.
  - err_clr=1 zeroes both on the next edge; clear wins over a same-cycle increment.
- Undefined: those ports and counters are absent; overflow/underflow pulses are unchanged.

Decomposition:
- Package lutram_fifo_pkg holds:
  - the ptr/count width calculation (ADDR_WIDTH+1);
  - ERR_CNT_WIDTH=16 and ERR_CNT_MAX constants;
  - the parameter legality check ranges.
- Sub-module: the storage is one xilinx_lutram instance (RAM_WIDTH=DATA_WIDTH, RAM_DEEP=ADDR_WIDTH).
- No other sub-module: pointer/flag logic stays in lutram_sync_fifo.

Test Plan (defaults, DEPTH=32):
- Reset, then idle → empty=1, aempty=1, full=0, count=0; rd_en pulse → underflow=1 the next cycle, count stays 0.
- Write 8'hA5 in cycle N → cycle N+1: empty=0, rd_data=8'hA5, count=1; rd_en → cycle N+2: empty=1.
- Write 0..31 back-to-back:
  - count reaches 28 → afull=1; count 32 → full=1.
  - 33rd write → overflow=1, count stays 32.
  - Drain reads back 0..31 in order.
- Fill to 32, then wr_en+rd_en together → read accepted, write dropped, overflow=1, count=31.
- Wrap-around: 100 cycles of random concurrent wr/rd at ~50% each → rd_data sequence matches a scoreboard, count equals the model every cycle.
- Assert rst_n low with count=17 → asynchronously count=0, empty=1, full=0. With the macro defined, two overflows give ovf_cnt=2, and err_clr then gives 0.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// Shared constants for the LUT-RAM backed FIFO: pointer/count sizing,
// error-counter width and the legal parameter ranges.
package lutram_fifo_pkg;

    localparam int ERR_CNT_WIDTH = 16;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = 16'hFFFF;

    localparam int ADDR_WIDTH_MIN = 5;
    localparam int ADDR_WIDTH_MAX = 8;

    // Pointers and occupancy carry one extra bit so full and empty are distinct.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit params_legal(input int addr_width, input int afull_level,
                                        input int aempty_level);
        int depth;
        depth = 1 << addr_width;
        return (addr_width >= ADDR_WIDTH_MIN) && (addr_width <= ADDR_WIDTH_MAX) &&
               (afull_level >= 1) && (afull_level <= depth) &&
               (aempty_level >= 0) && (aempty_level <= depth - 1);
    endfunction

endpackage

// File: rtl/xilinx_lutram.sv
// Distributed-RAM storage: synchronous write, asynchronous read. Contents are
// never cleared; rst only clears the held read value used when rden is low.
module xilinx_lutram #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEEP  = 5
) (
    input  logic                 clk_wr,
    input  logic                 clk_rd,
    input  logic                 rst,
    input  logic                 wren,
    input  logic [RAM_DEEP-1:0]  wraddress,
    input  logic [RAM_WIDTH-1:0] data,
    input  logic                 rden,
    input  logic [RAM_DEEP-1:0]  rdaddress,
    output logic [RAM_WIDTH-1:0] q
);

    logic [RAM_WIDTH-1:0] mem_r [2**RAM_DEEP];
    logic [RAM_WIDTH-1:0] q_hold_r;

    // Write port.
    always_ff @(posedge clk_wr) begin
        if (wren) begin
            mem_r[wraddress] <= data;
        end
    end

    // Hold the last read value so q is stable while rden is low.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            q_hold_r <= {RAM_WIDTH{1'b0}};
        end else if (rden) begin
            q_hold_r <= mem_r[rdaddress];
        end else begin
            q_hold_r <= q_hold_r;
        end
    end

    // Asynchronous read port.
    always_comb begin
        q = q_hold_r;
        if (rden) begin
            q = mem_r[rdaddress];
        end else begin
            q = q_hold_r;
        end
    end

endmodule

// File: rtl/lutram_sync_fifo.sv
// Single-clock FWFT FIFO controller around one xilinx_lutram instance.
// Define LUTRAM_SYNC_FIFO_ERR_STAT_EN to add saturating overflow/underflow counters.
module lutram_sync_fifo
    import lutram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_LEVEL  = 28,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  afull,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
`ifdef LUTRAM_SYNC_FIFO_ERR_STAT_EN
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] ovf_cnt,
    output logic [ERR_CNT_WIDTH-1:0] udf_cnt,
`endif
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_C  = PW'(2**ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LEVEL);
    localparam logic [PW-1:0] ONE_C    = PW'(1);

    logic [PW-1:0] wr_ptr_r, rd_ptr_r, count_r, count_nxt_s;
    logic          full_r, afull_r, empty_r, aempty_r, overflow_r, underflow_r;
    logic          wr_acc_s, rd_acc_s;

    assign wr_acc_s  = wr_en & ~full_r;
    assign rd_acc_s  = rd_en & ~empty_r;
    assign full      = full_r;
    assign afull     = afull_r;
    assign empty     = empty_r;
    assign aempty    = aempty_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

    xilinx_lutram #(
        .RAM_WIDTH(DATA_WIDTH),
        .RAM_DEEP (ADDR_WIDTH)
    ) u_ram (
        .clk_wr   (clk),
        .clk_rd   (clk),
        .rst      (1'b0),
        .wren     (wr_acc_s),
        .wraddress(wr_ptr_r[ADDR_WIDTH-1:0]),
        .data     (wr_data),
        .rden     (1'b1),
        .rdaddress(rd_ptr_r[ADDR_WIDTH-1:0]),
        .q        (rd_data)
    );

    // Next occupancy: a simultaneous accepted write and read cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, and flags registered from the next-state count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {PW{1'b0}};
            full_r      <= 1'b0;
            afull_r     <= 1'b0;
            empty_r     <= 1'b1;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            afull_r     <= (count_nxt_s >= AFULL_C);
            empty_r     <= (count_nxt_s == {PW{1'b0}});
            aempty_r    <= (count_nxt_s <= AEMPTY_C);
            overflow_r  <= wr_en & full_r;
            underflow_r <= rd_en & empty_r;
        end
    end

`ifdef LUTRAM_SYNC_FIFO_ERR_STAT_EN
    logic [ERR_CNT_WIDTH-1:0] ovf_cnt_r, udf_cnt_r;

    assign ovf_cnt = ovf_cnt_r;
    assign udf_cnt = udf_cnt_r;

    // Saturating error counters; a clear takes priority over a same-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
            udf_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
        end else if (err_clr) begin
            ovf_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
            udf_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            if (overflow_r && (ovf_cnt_r != ERR_CNT_MAX)) begin
                ovf_cnt_r <= ovf_cnt_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (underflow_r && (udf_cnt_r != ERR_CNT_MAX)) begin
                udf_cnt_r <= udf_cnt_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule
